// File: rtl/rope_collision_detector.sv
// Rope/player overlap detector: accumulates overlap pixels per video frame, reports them
// at each startOfFrame and debounces the per-frame hit flag into the onRope level.
module rope_collision_detector #(
   parameter int GRAB_FRAMES    = 2,
   parameter int RELEASE_FRAMES = 3,
   parameter int COUNT_W        = 16
) (
   input  logic               clk,
   input  logic               resetN,
   input  logic               startOfFrame,
   input  logic               enable,
   input  logic               ropeDR,
   input  logic [3:0]         ropeHitEdge,
   input  logic               playerDR,
   output logic               collision,
   output logic [3:0]         collisionEdge,
   output logic [COUNT_W-1:0] overlapCount,
   output logic               onRope
);

   typedef enum logic [1:0] {ST_OFF, ST_ARMING, ST_ON, ST_RELEASING} rope_state_t;

   localparam logic [3:0]         GRAB_N    = 4'(GRAB_FRAMES);
   localparam logic [3:0]         RELEASE_N = 4'(RELEASE_FRAMES);
   localparam logic [COUNT_W-1:0] CNT_MAX   = '1;

   logic               overlap;
   logic               hitSeen;
   logic [3:0]         edgeAcc;
   logic [COUNT_W-1:0] cnt;
   logic [3:0]         frameCnt;
   rope_state_t        state;

   assign overlap = enable & ropeDR & playerDR;

   // The startOfFrame pixel already belongs to the new frame, so accumulators reload rather than clear.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         hitSeen <= 1'b0;
         edgeAcc <= 4'h0;
         cnt     <= '0;
      end else if (startOfFrame) begin
         hitSeen <= overlap;
         edgeAcc <= overlap ? ropeHitEdge : 4'h0;
         cnt     <= overlap ? COUNT_W'(1) : '0;
      end else if (overlap) begin
         hitSeen <= 1'b1;
         edgeAcc <= edgeAcc | ropeHitEdge;
         if (cnt != CNT_MAX) begin
            cnt <= cnt + COUNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         collision     <= 1'b0;
         collisionEdge <= 4'h0;
         overlapCount  <= '0;
      end else begin
         collision <= startOfFrame & hitSeen;
         if (startOfFrame) begin
            collisionEdge <= edgeAcc;
            overlapCount  <= cnt;
         end
      end
   end

   // Debounce: onRope follows hitSeen only after enough consecutive agreeing frames.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state    <= ST_OFF;
         frameCnt <= 4'd0;
         onRope   <= 1'b0;
      end else if (startOfFrame) begin
         case (state)
            ST_OFF: begin
               if (hitSeen) begin
                  frameCnt <= 4'd1;
                  if (GRAB_N == 4'd1) begin
                     state  <= ST_ON;
                     onRope <= 1'b1;
                  end else begin
                     state <= ST_ARMING;
                  end
               end
            end
            ST_ARMING: begin
               if (hitSeen) begin
                  if (frameCnt + 4'd1 == GRAB_N) begin
                     state    <= ST_ON;
                     frameCnt <= 4'd0;
                     onRope   <= 1'b1;
                  end else begin
                     frameCnt <= frameCnt + 4'd1;
                  end
               end else begin
                  state    <= ST_OFF;
                  frameCnt <= 4'd0;
               end
            end
            ST_ON: begin
               if (!hitSeen) begin
                  frameCnt <= 4'd1;
                  if (RELEASE_N == 4'd1) begin
                     state  <= ST_OFF;
                     onRope <= 1'b0;
                  end else begin
                     state <= ST_RELEASING;
                  end
               end
            end
            ST_RELEASING: begin
               if (!hitSeen) begin
                  if (frameCnt + 4'd1 == RELEASE_N) begin
                     state    <= ST_OFF;
                     frameCnt <= 4'd0;
                     onRope   <= 1'b0;
                  end else begin
                     frameCnt <= frameCnt + 4'd1;
                  end
               end else begin
                  state    <= ST_ON;
                  frameCnt <= 4'd0;
               end
            end
            default: begin
               state    <= ST_OFF;
               frameCnt <= 4'd0;
               onRope   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rope_collision_detector.sv
// Self-checking bench for rope_collision_detector: a frame model pushes expected reports
// into a queue at each startOfFrame; they are popped and compared one cycle later.
module tb_rope_collision_detector;

   localparam int GRAB = 2;
   localparam int REL  = 3;

   typedef struct {
      logic        col;
      logic [3:0]  hitEdge;
      logic [15:0] cnt;
      logic [3:0]  cnt4;
      logic        onr;
   } report_t;

   logic        clk = 1'b0;
   logic        resetN;
   logic        startOfFrame, enable, ropeDR, playerDR;
   logic [3:0]  ropeHitEdge;
   logic        collision, onRope, collisionS, onRopeS;
   logic [3:0]  collisionEdge, collisionEdgeS;
   logic [15:0] overlapCount;
   logic [3:0]  overlapCountS;

   report_t sbq[$];
   report_t expRep;
   report_t heldRep;
   logic    mHit;
   logic [3:0] mEdge;
   int      mCnt, mRun;
   logic    mOn;
   int      nChecks = 0;
   int      nFails  = 0;

   always #5 clk = ~clk;

   rope_collision_detector #(.GRAB_FRAMES(GRAB), .RELEASE_FRAMES(REL), .COUNT_W(16)) dut (
      .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .enable(enable),
      .ropeDR(ropeDR), .ropeHitEdge(ropeHitEdge), .playerDR(playerDR),
      .collision(collision), .collisionEdge(collisionEdge),
      .overlapCount(overlapCount), .onRope(onRope)
   );

   rope_collision_detector #(.GRAB_FRAMES(GRAB), .RELEASE_FRAMES(REL), .COUNT_W(4)) dutSat (
      .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .enable(enable),
      .ropeDR(ropeDR), .ropeHitEdge(ropeHitEdge), .playerDR(playerDR),
      .collision(collisionS), .collisionEdge(collisionEdgeS),
      .overlapCount(overlapCountS), .onRope(onRopeS)
   );

   task automatic clearModel();
      mHit = 1'b0;
      mEdge = 4'h0;
      mCnt = 0;
      mRun = 0;
      mOn = 1'b0;
      sbq.delete();
   endtask

   // Drives one pixel at a negedge, updates the model, and returns at the next negedge.
   task automatic step(input logic sof, input logic en, input logic rdr, input logic pdr,
                       input logic [3:0] he);
      logic    ov;
      report_t r;
      startOfFrame = sof;
      enable = en;
      ropeDR = rdr;
      playerDR = pdr;
      ropeHitEdge = he;
      ov = en & rdr & pdr;
      if (sof) begin
         if (!mOn) begin
            mRun = mHit ? mRun + 1 : 0;
            if (mRun == GRAB) begin mOn = 1'b1; mRun = 0; end
         end else begin
            mRun = mHit ? 0 : mRun + 1;
            if (mRun == REL) begin mOn = 1'b0; mRun = 0; end
         end
         r.col = mHit;
         r.hitEdge = mEdge;
         r.cnt = (mCnt > 65535) ? 16'hFFFF : 16'(mCnt);
         r.cnt4 = (mCnt > 15) ? 4'hF : 4'(mCnt);
         r.onr = mOn;
         sbq.push_back(r);
         mHit = ov;
         mEdge = ov ? he : 4'h0;
         mCnt = ov ? 1 : 0;
      end else if (ov) begin
         mHit = 1'b1;
         mEdge = mEdge | he;
         mCnt++;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic doReset();
      resetN = 1'b0;
      startOfFrame = 1'b0; enable = 1'b0; ropeDR = 1'b0; playerDR = 1'b0; ropeHitEdge = 4'h0;
      clearModel();
      @(negedge clk);
      @(negedge clk);
      resetN = 1'b1;
   endtask

   task automatic test_reset();
      resetN = 1'b0;
      startOfFrame = 1'b1; enable = 1'b1; ropeDR = 1'b1; playerDR = 1'b1; ropeHitEdge = 4'hF;
      @(negedge clk);
      @(negedge clk);
      nChecks++;
      if ({collision, collisionEdge, overlapCount, onRope, collisionS, collisionEdgeS, overlapCountS, onRopeS} !== '0) begin
         nFails++;
         $display("[TB] FAIL reset_state: got col=%0b edge=%h cnt=%0d on=%0b satcnt=%0d, expected all zero",
                  collision, collisionEdge, overlapCount, onRope, overlapCountS);
      end
      doReset();
   endtask

   task automatic test_no_overlap();
      for (int f = 0; f < 3; f++) begin
         step(1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
         expRep = sbq.pop_front();
         nChecks++;
         if ({collision, collisionEdge, overlapCount, overlapCountS, onRope} !== {expRep.col, expRep.hitEdge, expRep.cnt, expRep.cnt4, expRep.onr}) begin
            nFails++;
            $display("[TB] FAIL no_overlap_report: got col=%0b edge=%h cnt=%0d/%0d on=%0b, expected col=%0b edge=%h cnt=%0d/%0d on=%0b",
                     collision, collisionEdge, overlapCount, overlapCountS, onRope, expRep.col, expRep.hitEdge, expRep.cnt, expRep.cnt4, expRep.onr);
         end
         for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b1, i[0], ~i[0], 4'hF);
            nChecks++;
            if ({collision, collisionEdge, overlapCount, onRope} !== '0) begin
               nFails++;
               $display("[TB] FAIL no_overlap_idle: got col=%0b edge=%h cnt=%0d on=%0b, expected all zero",
                        collision, collisionEdge, overlapCount, onRope);
            end
         end
      end
   endtask

   task automatic test_edge_accum();
      logic [3:0] eds [5] = '{4'h8, 4'h4, 4'h0, 4'h0, 4'h1};
      for (int k = 0; k < 5; k++) begin
         step(1'b0, 1'b1, 1'b1, 1'b1, eds[k]);
         step(1'b0, 1'b1, 1'b1, 1'b0, 4'h2);
      end
      for (int rep = 0; rep < 2; rep++) begin
         step(1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
         expRep = sbq.pop_front();
         nChecks++;
         if ({collision, collisionEdge, overlapCount, overlapCountS, onRope} !== {expRep.col, expRep.hitEdge, expRep.cnt, expRep.cnt4, expRep.onr}) begin
            nFails++;
            $display("[TB] FAIL edge_accum_report: got col=%0b edge=%h cnt=%0d/%0d on=%0b, expected col=%0b edge=%h cnt=%0d/%0d on=%0b",
                     collision, collisionEdge, overlapCount, overlapCountS, onRope, expRep.col, expRep.hitEdge, expRep.cnt, expRep.cnt4, expRep.onr);
         end
         heldRep = expRep;
         for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
            nChecks++;
            if ({collision, collisionEdge, overlapCount} !== {1'b0, heldRep.hitEdge, heldRep.cnt}) begin
               nFails++;
               $display("[TB] FAIL edge_accum_hold: got col=%0b edge=%h cnt=%0d, expected col=0 edge=%h cnt=%0d",
                        collision, collisionEdge, overlapCount, heldRep.hitEdge, heldRep.cnt);
            end
         end
      end
   endtask

   task automatic test_grab_release();
      int pat [8] = '{1, 1, 0, 0, 1, 0, 0, 0};
      doReset();
      for (int f = 0; f < 9; f++) begin
         if (f > 0) begin
            for (int i = 0; i < 3; i++) step(1'b0, 1'b1, pat[f-1] != 0, 1'b1, 4'h1);
         end
         step(1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
         expRep = sbq.pop_front();
         nChecks++;
         if ({collision, collisionEdge, overlapCount, onRope, onRopeS} !== {expRep.col, expRep.hitEdge, expRep.cnt, expRep.onr, expRep.onr}) begin
            nFails++;
            $display("[TB] FAIL grab_release_frame%0d: got col=%0b edge=%h cnt=%0d on=%0b/%0b, expected col=%0b edge=%h cnt=%0d on=%0b",
                     f, collision, collisionEdge, overlapCount, onRope, onRopeS, expRep.col, expRep.hitEdge, expRep.cnt, expRep.onr);
         end
      end
   endtask

   task automatic test_sof_overlap();
      doReset();
      step(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
      for (int rep = 0; rep < 2; rep++) begin
         step(1'b1, 1'b1, rep == 0, rep == 0, 4'h2);
         expRep = sbq.pop_front();
         nChecks++;
         if ({collision, collisionEdge, overlapCount, overlapCountS, onRope} !== {expRep.col, expRep.hitEdge, expRep.cnt, expRep.cnt4, expRep.onr}) begin
            nFails++;
            $display("[TB] FAIL sof_overlap_report%0d: got col=%0b edge=%h cnt=%0d/%0d on=%0b, expected col=%0b edge=%h cnt=%0d/%0d on=%0b",
                     rep, collision, collisionEdge, overlapCount, overlapCountS, onRope, expRep.col, expRep.hitEdge, expRep.cnt, expRep.cnt4, expRep.onr);
         end
         for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 4'h8);
      end
   endtask

   task automatic test_saturation();
      for (int f = 0; f < 3; f++) begin
         if (f == 1) for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b1, 1'b1, 4'h0);
         if (f == 2) for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 4'h8);
         step(1'b1, f == 2 ? 1'b0 : 1'b1, 1'b0, 1'b0, 4'h0);
         expRep = sbq.pop_front();
         nChecks++;
         if ({collision, collisionS, overlapCount, overlapCountS, collisionEdge} !== {expRep.col, expRep.col, expRep.cnt, expRep.cnt4, expRep.hitEdge}) begin
            nFails++;
            $display("[TB] FAIL saturation_frame%0d: got col=%0b/%0b cnt=%0d/%0d edge=%h, expected col=%0b cnt=%0d/%0d edge=%h",
                     f, collision, collisionS, overlapCount, overlapCountS, collisionEdge, expRep.col, expRep.cnt, expRep.cnt4, expRep.hitEdge);
         end
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b1, 4'h1);
      for (int rep = 0; rep < 2; rep++) begin
         step(1'b1, 1'b1, rep == 0, rep == 0, 4'h4);
         expRep = sbq.pop_front();
         nChecks++;
         if ({collision, collisionEdge, overlapCount, overlapCountS, onRope} !== {expRep.col, expRep.hitEdge, expRep.cnt, expRep.cnt4, expRep.onr}) begin
            nFails++;
            $display("[TB] FAIL back_to_back%0d: got col=%0b edge=%h cnt=%0d/%0d on=%0b, expected col=%0b edge=%h cnt=%0d/%0d on=%0b",
                     rep, collision, collisionEdge, overlapCount, overlapCountS, onRope, expRep.col, expRep.hitEdge, expRep.cnt, expRep.cnt4, expRep.onr);
         end
      end
      step(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
      nChecks++;
      if (collision !== 1'b0) begin
         nFails++;
         $display("[TB] FAIL back_to_back_pulse: got col=%0b, expected col=0", collision);
      end
   endtask

   task automatic test_reset_midframe();
      for (int f = 0; f < 4; f++) begin
         if (f == 3) begin
            for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b1, 1'b1, 4'h8);
            resetN = 1'b0;
            startOfFrame = 1'b0; enable = 1'b0; ropeDR = 1'b0; playerDR = 1'b0;
            #2;
            nChecks++;
            if ({collision, collisionEdge, overlapCount, onRope, onRopeS} !== '0) begin
               nFails++;
               $display("[TB] FAIL midframe_reset_outputs: got col=%0b edge=%h cnt=%0d on=%0b, expected all zero",
                        collision, collisionEdge, overlapCount, onRope);
            end
            clearModel();
            @(negedge clk);
            @(negedge clk);
            resetN = 1'b1;
         end
         for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 1'b1, 1'b1, 4'h1);
         step(1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
         expRep = sbq.pop_front();
         nChecks++;
         if ({collision, collisionEdge, overlapCount, onRope} !== {expRep.col, expRep.hitEdge, expRep.cnt, expRep.onr}) begin
            nFails++;
            $display("[TB] FAIL midframe_reset_frame%0d: got col=%0b edge=%h cnt=%0d on=%0b, expected col=%0b edge=%h cnt=%0d on=%0b",
                     f, collision, collisionEdge, overlapCount, onRope, expRep.col, expRep.hitEdge, expRep.cnt, expRep.onr);
         end
      end
   endtask

   initial begin
      resetN = 1'b0;
      startOfFrame = 1'b0; enable = 1'b0; ropeDR = 1'b0; playerDR = 1'b0; ropeHitEdge = 4'h0;
      clearModel();
      @(negedge clk);
      $display("[TB] starting rope_collision_detector bench");
      test_reset();
      test_no_overlap();
      test_edge_accum();
      test_grab_release();
      test_sof_overlap();
      test_saturation();
      test_back_to_back();
      test_reset_midframe();
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
